// File: rtl/pcs_byte_framer.sv
// Transmit-side PCS byte framer: wraps payload packets in STP/SDP ... END,
// inserts COM+SKP ordered sets between packets and idles with IDL.
module pcs_byte_framer #(
  parameter int unsigned SKP_INTERVAL = 16,
  parameter int unsigned SKP_COUNT    = 3,
  parameter logic [7:0]  COM          = 8'hbc,
  parameter logic [7:0]  SKP          = 8'h1c,
  parameter logic [7:0]  STP          = 8'hfb,
  parameter logic [7:0]  SDP          = 8'h5c,
  parameter logic [7:0]  END          = 8'hfd,
  parameter logic [7:0]  IDL          = 8'h7c
) (
  input  logic       clk,
  input  logic       reset_L,
  input  logic       pkt_valid,
  input  logic [7:0] pkt_data,
  input  logic       pkt_last,
  input  logic       pkt_type,
  output logic       pkt_ready,
  output logic       valid_out,
  output logic [7:0] data_out,
  output logic       data_err
);

  localparam logic [7:0] SKP_LAST = 8'(SKP_INTERVAL - 1);
  localparam logic [2:0] OS_LAST  = 3'(SKP_COUNT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    ENDS   = 3'd3,
    OS_COM = 3'd4,
    OS_SKP = 3'd5
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] skp_cnt;
  logic [2:0] os_cnt;
  logic       pkt_type_q, type_nxt;
  logic       os_pending;
  logic       vld_nxt, err_nxt;
  logic [7:0] data_nxt;

  // Payload bytes that collide with a control code are flagged downstream.
  function automatic logic is_ctrl(input logic [7:0] b);
    return (b == COM) || (b == SKP) || (b == STP) || (b == SDP) ||
           (b == END) || (b == IDL);
  endfunction

  assign os_pending = (skp_cnt == SKP_LAST);
  assign pkt_ready  = (state == DATA);

  always_comb begin
    state_nxt = state;
    type_nxt  = pkt_type_q;
    vld_nxt   = 1'b0;
    data_nxt  = IDL;
    err_nxt   = 1'b0;
    case (state)
      IDLE, ENDS: begin
        if (state == ENDS) begin
          vld_nxt  = 1'b1;
          data_nxt = END;
        end
        // Ordered sets win over starting the next packet.
        if (os_pending) begin
          state_nxt = OS_COM;
        end else if (pkt_valid) begin
          state_nxt = START;
          type_nxt  = pkt_type;
        end else begin
          state_nxt = IDLE;
        end
      end
      START: begin
        vld_nxt   = 1'b1;
        data_nxt  = pkt_type_q ? SDP : STP;
        state_nxt = DATA;
      end
      DATA: begin
        if (pkt_valid) begin
          vld_nxt  = 1'b1;
          data_nxt = pkt_data;
          err_nxt  = is_ctrl(pkt_data);
          if (pkt_last) state_nxt = ENDS;
        end
      end
      OS_COM: begin
        vld_nxt   = 1'b1;
        data_nxt  = COM;
        state_nxt = OS_SKP;
      end
      OS_SKP: begin
        vld_nxt  = 1'b1;
        data_nxt = SKP;
        if (os_cnt == OS_LAST) begin
          if (pkt_valid) begin
            state_nxt = START;
            type_nxt  = pkt_type;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state      <= IDLE;
      pkt_type_q <= 1'b0;
      skp_cnt    <= '0;
      os_cnt     <= '0;
      valid_out  <= 1'b0;
      data_out   <= IDL;
      data_err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      pkt_type_q <= type_nxt;
      valid_out  <= vld_nxt;
      data_out   <= data_nxt;
      data_err   <= err_nxt;
      if (state == OS_COM)  skp_cnt <= '0;
      else if (!os_pending) skp_cnt <= skp_cnt + 8'd1;
      if (state == OS_COM)      os_cnt <= '0;
      else if (state == OS_SKP) os_cnt <= os_cnt + 3'd1;
    end
  end

endmodule

// File: tb/tb_pcs_byte_framer.sv
// Randomized and directed bench for pcs_byte_framer against a symbol-stream model.
module tb_pcs_byte_framer;

  localparam int SKP_INTERVAL = 16;
  localparam int SKP_COUNT    = 3;
  localparam logic [7:0] COM = 8'hbc, SKP = 8'h1c, STP = 8'hfb,
                         SDP = 8'h5c, END = 8'hfd, IDL = 8'h7c;

  logic       clk = 1'b0;
  logic       reset_L = 1'b0;
  logic       pkt_valid = 1'b0;
  logic [7:0] pkt_data = 8'h00;
  logic       pkt_last = 1'b0;
  logic       pkt_type = 1'b0;
  logic       pkt_ready, valid_out, data_err;
  logic [7:0] data_out;

  pcs_byte_framer #(.SKP_INTERVAL(SKP_INTERVAL), .SKP_COUNT(SKP_COUNT)) dut (
    .clk(clk), .reset_L(reset_L), .pkt_valid(pkt_valid), .pkt_data(pkt_data),
    .pkt_last(pkt_last), .pkt_type(pkt_type), .pkt_ready(pkt_ready),
    .valid_out(valid_out), .data_out(data_out), .data_err(data_err));

  always #5 clk = ~clk;

  int    nchecks = 0;
  int    nfail = 0;
  int    ncycle = 0;
  string tname = "none";

  // Observed output stream of the current scenario.
  logic       obs_v[$];
  logic [7:0] obs_d[$];
  logic       obs_e[$];

  // Reference model: what symbol the link owes on each cycle.
  int         m_age;     // cycles since reset/COM, saturating
  int         m_os;      // -1 none, 0 COM owed, k = k-th SKP owed
  bit         m_start, m_type, m_in, m_end;
  logic       exp_v, exp_e;
  logic [7:0] exp_d;

  function automatic bit is_code(input logic [7:0] b);
    return b == COM || b == SKP || b == STP || b == SDP || b == END || b == IDL;
  endfunction

  task automatic model_reset();
    m_age = 0; m_os = -1; m_start = 0; m_type = 0; m_in = 0; m_end = 0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] d, input bit l, input bit t);
    bit com_now = 0, choose = 0, os_ok = 1;
    exp_v = 1; exp_e = 0; exp_d = IDL;
    if (m_os == 0) begin
      exp_d = COM; com_now = 1; m_os = 1;
    end else if (m_os > 0) begin
      exp_d = SKP;
      if (m_os == SKP_COUNT) begin m_os = -1; choose = 1; os_ok = 0; end
      else m_os++;
    end else if (m_start) begin
      exp_d = m_type ? SDP : STP; m_start = 0; m_in = 1;
    end else if (m_in) begin
      if (v) begin
        exp_d = d; exp_e = is_code(d);
        if (l) begin m_in = 0; m_end = 1; end
      end else begin
        exp_v = 0; exp_d = IDL;
      end
    end else if (m_end) begin
      exp_d = END; m_end = 0; choose = 1;
    end else begin
      exp_v = 0; exp_d = IDL; choose = 1;
    end
    if (choose) begin
      if (os_ok && m_age == SKP_INTERVAL - 1) m_os = 0;
      else if (v) begin m_start = 1; m_type = t; end
    end
    if (com_now) m_age = 0;
    else if (m_age < SKP_INTERVAL - 1) m_age++;
  endtask

  // One clock: drive inputs, step model at the edge, compare just after it.
  task automatic tick(input bit v, input logic [7:0] d, input bit l, input bit t, output bit acc);
    pkt_valid = v; pkt_data = d; pkt_last = l; pkt_type = t;
    #1;
    nchecks++;
    if (pkt_ready !== m_in) begin
      nfail++;
      $display("FAIL %s ready cycle %0d: got %b want %b", tname, ncycle, pkt_ready, m_in);
    end
    acc = pkt_ready && v;
    @(posedge clk);
    model_step(v, d, l, t);
    #1;
    ncycle++;
    nchecks++;
    if (valid_out !== exp_v || data_out !== exp_d || data_err !== exp_e) begin
      nfail++;
      $display("FAIL %s stream cycle %0d: v/d/e got %b/%h/%b want %b/%h/%b",
               tname, ncycle, valid_out, data_out, data_err, exp_v, exp_d, exp_e);
    end
    obs_v.push_back(valid_out); obs_d.push_back(data_out); obs_e.push_back(data_err);
  endtask

  task automatic idle_ticks(input int n);
    bit acc;
    for (int i = 0; i < n; i++) tick(0, 8'($urandom), 1'($urandom), 1'($urandom), acc);
  endtask

  task automatic send_pkt(input logic [7:0] q[$], input bit typ, input int stall_pct);
    int  idx = 0, guard = 0;
    bit  acc;
    while (idx < q.size()) begin
      if (guard++ > 2000) begin
        nchecks++; nfail++;
        $display("FAIL %s send timeout: accepted %0d want %0d", tname, idx, q.size());
        return;
      end
      if (int'($urandom_range(99)) < stall_pct)
        tick(0, 8'($urandom), 1'($urandom), 1'($urandom), acc);
      else
        tick(1, q[idx], idx == q.size() - 1, (idx > 0) ? 1'($urandom) : typ, acc);
      if (acc) idx++;
    end
  endtask

  task automatic do_reset();
    pkt_valid = 0; pkt_last = 0;
    reset_L = 0;
    @(posedge clk); #1;
    reset_L = 1;
    model_reset();
    obs_v.delete(); obs_d.delete(); obs_e.delete();
  endtask

  task automatic test_reset();
    tname = "reset";
    pkt_valid = 1; pkt_data = 8'h11; pkt_type = 0;
    repeat (3) @(posedge clk);
    #1;
    nchecks++;
    if (valid_out !== 1'b0 || data_out !== IDL || pkt_ready !== 1'b0 || data_err !== 1'b0) begin
      nfail++;
      $display("FAIL reset_hold: v/d/r/e got %b/%h/%b/%b want 0/7c/0/0",
               valid_out, data_out, pkt_ready, data_err);
    end
    pkt_valid = 0;
    reset_L = 1;
    model_reset();
  endtask

  task automatic test_single_tlp();
    logic [7:0] ed[6] = '{STP, 8'h11, 8'h22, 8'h33, END, IDL};
    logic       ev[6] = '{1, 1, 1, 1, 1, 0};
    tname = "single_tlp";
    obs_v.delete(); obs_d.delete(); obs_e.delete();
    send_pkt('{8'h11, 8'h22, 8'h33}, 0, 0);
    idle_ticks(3);
    for (int i = 0; i < 6; i++) begin
      nchecks++;
      if (obs_d[i+1] !== ed[i] || obs_v[i+1] !== ev[i]) begin
        nfail++;
        $display("FAIL single_tlp sym%0d: got %b/%h want %b/%h", i, obs_v[i+1], obs_d[i+1], ev[i], ed[i]);
      end
    end
  endtask

  task automatic test_dllp_stall();
    logic [7:0] ed[5] = '{SDP, 8'haa, IDL, 8'hbb, END};
    logic       ev[5] = '{1, 1, 0, 1, 1};
    bit acc;
    int guard = 0;
    tname = "dllp_stall";
    do_reset();
    do tick(1, 8'haa, 0, 1, acc); while (!acc && guard++ < 10);
    tick(0, 8'h00, 1, 0, acc);
    guard = 0;
    do tick(1, 8'hbb, 1, 1, acc); while (!acc && guard++ < 10);
    idle_ticks(2);
    for (int i = 0; i < 5; i++) begin
      nchecks++;
      if (obs_d[i+1] !== ed[i] || obs_v[i+1] !== ev[i]) begin
        nfail++;
        $display("FAIL dllp_stall sym%0d: got %b/%h want %b/%h", i, obs_v[i+1], obs_d[i+1], ev[i], ed[i]);
      end
    end
  endtask

  task automatic test_idle_os();
    int nv = 0;
    tname = "idle_os";
    do_reset();
    idle_ticks(60);
    // First COM is emitted the cycle after skp_cnt saturates; later ones recur
    // every SKP_INTERVAL+1 cycles (one cycle to clear, then count up again).
    for (int s = 0; s < 3; s++) begin
      int b = SKP_INTERVAL + s * (SKP_INTERVAL + 1);
      nchecks++;
      if (obs_d[b] !== COM || obs_d[b+1] !== SKP || obs_d[b+2] !== SKP || obs_d[b+3] !== SKP) begin
        nfail++;
        $display("FAIL idle_os set%0d at %0d: got %h %h %h %h want bc 1c 1c 1c",
                 s, b, obs_d[b], obs_d[b+1], obs_d[b+2], obs_d[b+3]);
      end
    end
    foreach (obs_v[i]) nv += int'(obs_v[i]);
    nchecks++;
    if (nv != 3 * (SKP_COUNT + 1)) begin
      nfail++;
      $display("FAIL idle_os valid count: got %0d want %0d", nv, 3 * (SKP_COUNT + 1));
    end
  endtask

  task automatic test_long_pkt();
    logic [7:0] q[$];
    int f = -1, s = -1;
    logic [7:0] after[5] = '{COM, SKP, SKP, SKP, STP};
    tname = "long_pkt";
    do_reset();
    for (int i = 0; i < 25; i++) begin
      logic [7:0] b = 8'($urandom);
      if (is_code(b)) b = b ^ 8'h01;
      q.push_back(b);
    end
    send_pkt(q, 0, 0);
    send_pkt('{8'h55}, 0, 0);
    idle_ticks(3);
    foreach (obs_d[i]) begin
      if (s < 0 && obs_d[i] === STP) s = i;
      if (f < 0 && obs_d[i] === END) f = i;
    end
    nchecks++;
    if (f < 0 || s < 0 || f + 5 >= obs_d.size()) begin
      nfail++;
      $display("FAIL long_pkt frame: stp at %0d end at %0d", s, f);
    end else begin
      for (int i = s; i < f; i++) begin
        nchecks++;
        if (obs_d[i] === COM) begin
          nfail++;
          $display("FAIL long_pkt com_inside at %0d: got %h want non-bc", i, obs_d[i]);
        end
      end
      for (int i = 0; i < 5; i++) begin
        nchecks++;
        if (obs_d[f+1+i] !== after[i]) begin
          nfail++;
          $display("FAIL long_pkt after_end%0d: got %h want %h", i, obs_d[f+1+i], after[i]);
        end
      end
    end
  endtask

  task automatic test_data_err();
    tname = "data_err";
    do_reset();
    send_pkt('{8'hbc, 8'h10}, 0, 0);
    idle_ticks(2);
    nchecks++;
    if (obs_d[2] !== 8'hbc || obs_e[2] !== 1'b1 || obs_e[1] !== 1'b0) begin
      nfail++;
      $display("FAIL data_err bc: got d=%h e=%b (prev e=%b) want bc/1 (prev 0)", obs_d[2], obs_e[2], obs_e[1]);
    end
    nchecks++;
    if (obs_d[3] !== 8'h10 || obs_e[3] !== 1'b0) begin
      nfail++;
      $display("FAIL data_err 10: got d=%h e=%b want 10/0", obs_d[3], obs_e[3]);
    end
  endtask

  task automatic test_reset_mid();
    bit acc;
    tname = "reset_mid";
    do_reset();
    for (int i = 0; i < 4; i++) tick(1, 8'h20 + 8'(i), 0, 0, acc);
    #3;
    reset_L = 0;
    #1;
    nchecks++;
    if (valid_out !== 1'b0 || data_out !== IDL || pkt_ready !== 1'b0 || data_err !== 1'b0) begin
      nfail++;
      $display("FAIL reset_mid async: v/d/r/e got %b/%h/%b/%b want 0/7c/0/0",
               valid_out, data_out, pkt_ready, data_err);
    end
    @(posedge clk); #1;
    reset_L = 1;
    model_reset();
    obs_v.delete(); obs_d.delete(); obs_e.delete();
    send_pkt('{8'h42}, 1, 0);
    idle_ticks(2);
    nchecks++;
    if (obs_v[1] !== 1'b1 || obs_d[1] !== SDP || obs_d[2] !== 8'h42 || obs_d[3] !== END) begin
      nfail++;
      $display("FAIL reset_mid restart: got %h %h %h want 5c 42 fd", obs_d[1], obs_d[2], obs_d[3]);
    end
  endtask

  task automatic test_random();
    tname = "random";
    for (int p = 0; p < 60; p++) begin
      logic [7:0] q[$];
      int n = int'($urandom_range(1, 20));
      for (int i = 0; i < n; i++) begin
        logic [7:0] b = 8'($urandom);
        if ($urandom_range(7) == 0) begin
          case ($urandom_range(5))
            0: b = COM; 1: b = SKP; 2: b = STP; 3: b = SDP; 4: b = END; default: b = IDL;
          endcase
        end
        q.push_back(b);
      end
      send_pkt(q, 1'($urandom), 30);
      idle_ticks(int'($urandom_range(0, 5)));
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_tlp();
    test_dllp_stall();
    test_idle_os();
    test_long_pkt();
    test_data_err();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
    $finish;
  end

endmodule
